// File: rtl/fpu_seq_pkg.sv
// Shared types and constants for the fpu_cmd_seq command sequencer.
package fpu_seq_pkg;

  localparam int CMD_DATA_W = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD_SETUP,
    S_LD_WRITE,
    S_EXEC,
    S_GAP
  } state_t;

  localparam logic [2:0] OP_LOAD      = 3'b100;
  localparam logic [2:0] OP_ARITH_MAX = 3'b011;

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_TMO = 2'b01;
  localparam logic [1:0] ST_ILL = 2'b10;

  typedef struct packed {
    logic [2:0]            op;
    logic [4:0]            a1;
    logic [4:0]            a2;
    logic [4:0]            a3;
    logic [CMD_DATA_W-1:0] data;
  } cmd_t;

  function automatic logic is_arith(input logic [2:0] op);
    return op <= OP_ARITH_MAX;
  endfunction

endpackage

// File: rtl/fpu_cmd_fifo.sv
// Synchronous command FIFO with registered full/empty flags and no write-through bypass.
module fpu_cmd_fifo
  import fpu_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rstp,
  input  logic push,
  input  logic pop,
  input  cmd_t din,
  output cmd_t dout,
  output logic full,
  output logic empty
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  cmd_t             mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             full_reg, empty_reg;
  logic             do_push, do_pop;

  // A push while full is refused even if the same cycle pops.
  assign do_push = push && !full_reg;
  assign do_pop  = pop && !empty_reg;

  always_comb begin
    count_next = count_reg;
    if (do_push && !do_pop)
      count_next = count_reg + CNT_W'(1);
    else if (!do_push && do_pop)
      count_next = count_reg - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rstp) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
      full_reg  <= (count_next == CNT_W'(DEPTH));
      empty_reg <= (count_next == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  assign dout  = mem[rd_ptr_reg];
  assign full  = full_reg;
  assign empty = empty_reg;

endmodule

// File: rtl/fpu_cmd_seq.sv
// Issue stage in front of the fpu: queues commands, sequences load/exec handshakes, returns results.
// Optional EXEC watchdog enabled by defining FPU_SEQ_TIMEOUT_EN.
module fpu_cmd_seq
  import fpu_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int TMO   = 63
) (
  input  logic             clk,
  input  logic             rstp,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [4:0]       cmd_a1,
  input  logic [4:0]       cmd_a2,
  input  logic [4:0]       cmd_a3,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             fpu_enable,
  output logic             fpu_ld,
  output logic [2:0]       fpu_opcode,
  output logic [4:0]       fpu_addr1,
  output logic [4:0]       fpu_addr2,
  output logic [4:0]       fpu_addr3,
  output logic [WIDTH-1:0] fpu_inp,
  input  logic             fpu_done,
  input  logic [WIDTH-1:0] fpu_out,
  input  logic [4:0]       fpu_flags,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic [4:0]       res_flags,
  output logic [1:0]       res_status,
  output logic             busy
);

  localparam int CNT_W = $clog2(TMO + 1);

  cmd_t   cmd_in, head;
  logic   fifo_full, fifo_empty, pop;
  state_t state_reg;

  logic             fpu_enable_reg, fpu_ld_reg;
  logic [2:0]       fpu_opcode_reg;
  logic [4:0]       fpu_addr1_reg, fpu_addr2_reg, fpu_addr3_reg;
  logic [WIDTH-1:0] fpu_inp_reg;
  logic [CNT_W-1:0] exec_cnt_reg;
  logic             res_valid_reg;
  logic [WIDTH-1:0] res_data_reg;
  logic [4:0]       res_flags_reg;
  logic [1:0]       res_status_reg;

  assign cmd_in = '{op: cmd_op, a1: cmd_a1, a2: cmd_a2, a3: cmd_a3,
                    data: CMD_DATA_W'(cmd_data)};

  fpu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rstp  (rstp),
    .push  (cmd_valid),
    .pop   (pop),
    .din   (cmd_in),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Loads never touch the result register; everything else needs it free (or draining now).
  assign pop = (state_reg == S_IDLE) && !fifo_empty &&
               ((head.op == OP_LOAD) || !res_valid_reg || res_ready);

  always_ff @(posedge clk) begin
    if (rstp) begin
      state_reg      <= S_IDLE;
      fpu_enable_reg <= 1'b0;
      fpu_ld_reg     <= 1'b0;
      fpu_opcode_reg <= OP_LOAD;
      fpu_addr1_reg  <= '0;
      fpu_addr2_reg  <= '0;
      fpu_addr3_reg  <= '0;
      fpu_inp_reg    <= '0;
      exec_cnt_reg   <= '0;
      res_valid_reg  <= 1'b0;
      res_data_reg   <= '0;
      res_flags_reg  <= '0;
      res_status_reg <= ST_OK;
    end else begin
      if (res_valid_reg && res_ready) res_valid_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (pop) begin
            if (head.op == OP_LOAD) begin
              state_reg      <= S_LD_SETUP;
              fpu_enable_reg <= 1'b1;
              fpu_ld_reg     <= 1'b0;
              fpu_addr1_reg  <= head.a1;
              fpu_addr2_reg  <= head.a2;
              fpu_addr3_reg  <= head.a3;
              fpu_inp_reg    <= WIDTH'(head.data);
            end else if (is_arith(head.op)) begin
              state_reg      <= S_EXEC;
              fpu_enable_reg <= 1'b1;
              fpu_opcode_reg <= head.op;
              fpu_addr1_reg  <= head.a1;
              fpu_addr2_reg  <= head.a2;
              fpu_addr3_reg  <= head.a3;
              exec_cnt_reg   <= '0;
            end else begin
              res_valid_reg  <= 1'b1;
              res_data_reg   <= '0;
              res_flags_reg  <= '0;
              res_status_reg <= ST_ILL;
            end
          end
        end
        S_LD_SETUP: begin
          state_reg  <= S_LD_WRITE;
          fpu_ld_reg <= 1'b1;
        end
        S_LD_WRITE: begin
          state_reg      <= S_GAP;
          fpu_enable_reg <= 1'b0;
          fpu_ld_reg     <= 1'b0;
        end
        S_EXEC: begin
          // done is ignored in the first EXEC cycle (count still zero).
          if (exec_cnt_reg != '0 && fpu_done) begin
            state_reg      <= S_GAP;
            fpu_enable_reg <= 1'b0;
            fpu_opcode_reg <= OP_LOAD;
            res_valid_reg  <= 1'b1;
            res_data_reg   <= fpu_out;
            res_flags_reg  <= fpu_flags;
            res_status_reg <= ST_OK;
          end
`ifdef FPU_SEQ_TIMEOUT_EN
          else if (exec_cnt_reg == CNT_W'(TMO - 1)) begin
            state_reg      <= S_GAP;
            fpu_enable_reg <= 1'b0;
            fpu_opcode_reg <= OP_LOAD;
            res_valid_reg  <= 1'b1;
            res_data_reg   <= '0;
            res_flags_reg  <= '0;
            res_status_reg <= ST_TMO;
          end
`endif
          else if (exec_cnt_reg != CNT_W'(TMO)) begin
            exec_cnt_reg <= exec_cnt_reg + CNT_W'(1);
          end
        end
        S_GAP:   state_reg <= S_IDLE;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready  = !fifo_full;
  assign fpu_enable = fpu_enable_reg;
  assign fpu_ld     = fpu_ld_reg;
  assign fpu_opcode = fpu_opcode_reg;
  assign fpu_addr1  = fpu_addr1_reg;
  assign fpu_addr2  = fpu_addr2_reg;
  assign fpu_addr3  = fpu_addr3_reg;
  assign fpu_inp    = fpu_inp_reg;
  assign res_valid  = res_valid_reg;
  assign res_data   = res_data_reg;
  assign res_flags  = res_flags_reg;
  assign res_status = res_status_reg;
  assign busy       = !fifo_empty || (state_reg != S_IDLE);

endmodule

// File: tb/tb_fpu_cmd_seq.sv
// Self-checking bench for fpu_cmd_seq: behavioural fpu model, issue/result scoreboards, vector table.
module tb_fpu_cmd_seq;
  import fpu_seq_pkg::*;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
`ifdef FPU_SEQ_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 63;
`endif

  logic             clk = 1'b0;
  logic             rstp = 1'b1;
  logic             cmd_valid, cmd_ready;
  logic [2:0]       cmd_op;
  logic [4:0]       cmd_a1, cmd_a2, cmd_a3;
  logic [WIDTH-1:0] cmd_data;
  logic             fpu_enable, fpu_ld, fpu_done;
  logic [2:0]       fpu_opcode;
  logic [4:0]       fpu_addr1, fpu_addr2, fpu_addr3;
  logic [WIDTH-1:0] fpu_inp, fpu_out;
  logic [4:0]       fpu_flags;
  logic             res_valid, res_ready, busy;
  logic [WIDTH-1:0] res_data;
  logic [4:0]       res_flags;
  logic [1:0]       res_status;

  always #5 clk = ~clk;

  fpu_cmd_seq #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TMO(TMO)) dut (
    .clk(clk), .rstp(rstp),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a1(cmd_a1), .cmd_a2(cmd_a2), .cmd_a3(cmd_a3), .cmd_data(cmd_data),
    .fpu_enable(fpu_enable), .fpu_ld(fpu_ld), .fpu_opcode(fpu_opcode),
    .fpu_addr1(fpu_addr1), .fpu_addr2(fpu_addr2), .fpu_addr3(fpu_addr3),
    .fpu_inp(fpu_inp), .fpu_done(fpu_done), .fpu_out(fpu_out), .fpu_flags(fpu_flags),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_flags(res_flags), .res_status(res_status), .busy(busy)
  );

  // fpu model: done in the done_delay-th arithmetic enable cycle (0 = never); result encodes the request.
  int done_delay = 2;
  int exec_cyc = 0;
  always @(posedge clk) exec_cyc <= (fpu_enable && !fpu_opcode[2]) ? exec_cyc + 1 : 0;
  assign fpu_done  = fpu_enable && !fpu_opcode[2] && done_delay != 0 && exec_cyc >= done_delay - 1;
  assign fpu_out   = {fpu_addr3, fpu_addr2, fpu_addr1, fpu_opcode, 14'h1A5};
  assign fpu_flags = fpu_addr1 ^ fpu_addr2 ^ {2'b00, fpu_opcode};

  typedef struct packed {logic [31:0] data; logic [4:0] flags; logic [1:0] status;} res_t;
  typedef struct packed {logic [2:0] op; logic [4:0] a1; logic [4:0] a2; logic [4:0] a3; logic [31:0] inp;} iss_t;
  typedef struct {
    logic [2:0] op; logic [4:0] a1; logic [4:0] a2; logic [4:0] a3; logic [31:0] data;
    int dly; bit has_res; res_t exp;
  } vec_t;

  res_t        sb_q[$];
  iss_t        iss_q[$];
  res_t        sb_e;
  iss_t        iss_e;
  logic [31:0] last_inp = '0;
  logic        prev_en = 1'b0;
  int          checks = 0;
  int          errors = 0;
  vec_t        vec[8];

  function automatic res_t exp_res(input logic [2:0] op, input logic [4:0] a1, input logic [4:0] a2,
                                   input logic [4:0] a3);
    if (op <= 3'b011) return '{data: {a3, a2, a1, op, 14'h1A5}, flags: a1 ^ a2 ^ {2'b00, op}, status: ST_OK};
    return '{data: 32'h0, flags: 5'h0, status: ST_ILL};
  endfunction

  function automatic vec_t mk(input logic [2:0] op, input logic [4:0] a1, input logic [4:0] a2,
                              input logic [4:0] a3, input logic [31:0] data, input int dly);
    vec_t v;
    v.op = op; v.a1 = a1; v.a2 = a2; v.a3 = a3; v.data = data; v.dly = dly;
    v.has_res = (op != OP_LOAD);
    v.exp = exp_res(op, a1, a2, a3);
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [2:0] op, input logic [4:0] a1, input logic [4:0] a2,
                          input logic [4:0] a3, input logic [31:0] data, input bit has_res, input res_t exp);
    int n = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_a1 = a1; cmd_a2 = a2; cmd_a3 = a3; cmd_data = data;
    while (!cmd_ready && n < 200) begin
      tick();
      n++;
    end
    if (!cmd_ready) begin
      checks++; errors++;
      $display("FAIL push_timeout cmd_ready=%0b required=1", cmd_ready);
      cmd_valid = 1'b0;
      return;
    end
    tick();
    cmd_valid = 1'b0;
    $display("push op=%0h a1=%0d a2=%0d a3=%0d data=%08h", op, a1, a2, a3, data);
    if (op == OP_LOAD) begin
      last_inp = data;
      iss_q.push_back({op, a1, a2, a3, data});
    end else if (op <= 3'b011) begin
      iss_q.push_back({op, a1, a2, a3, last_inp});
    end
    if (has_res) sb_q.push_back(exp);
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while ((busy || res_valid) && n < lim) begin
      tick();
      n++;
    end
    if (busy || res_valid) begin
      checks++; errors++;
      $display("FAIL idle_timeout busy=%0b res_valid=%0b required=0", busy, res_valid);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_enable"}, fpu_enable, 0);
    chk({tag, "_ld"}, fpu_ld, 0);
    chk({tag, "_opcode"}, fpu_opcode, 3'b100);
    chk({tag, "_addrs"}, {fpu_addr1, fpu_addr2, fpu_addr3}, 0);
    chk({tag, "_inp"}, fpu_inp, 0);
    chk({tag, "_res"}, {res_valid, res_data, res_flags, res_status}, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // Issue and result monitors, sampled on the falling edge.
  always @(negedge clk) begin
    if (fpu_enable && !prev_en) begin
      if (iss_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL issue_unexpected op=%0h a1=%0d required=none", fpu_opcode, fpu_addr1);
      end else begin
        iss_e = iss_q.pop_front();
        chk("issue", {fpu_opcode, fpu_addr1, fpu_addr2, fpu_addr3, fpu_inp}, iss_e);
      end
    end
    prev_en = fpu_enable;
    if (res_valid && res_ready) begin
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL result_unexpected data=%08h status=%0d required=none", res_data, res_status);
      end else begin
        sb_e = sb_q.pop_front();
        $display("result data=%08h flags=%02h status=%0d", res_data, res_flags, res_status);
        chk("result", {res_data, res_flags, res_status}, sb_e);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not terminate");
  end

  initial begin
    int n, en_cnt;
    vec[0] = mk(OP_LOAD, 5'd3, 5'd0, 5'd0, 32'h40490FDB, 0);
    vec[1] = mk(3'b000, 5'd3, 5'd3, 5'd4, 32'h0, 2);
    vec[2] = mk(3'b001, 5'd1, 5'd2, 5'd5, 32'h0, 5);
    vec[3] = mk(3'b011, 5'd31, 5'd30, 5'd29, 32'h0, 3);
    vec[4] = mk(3'b101, 5'd2, 5'd2, 5'd2, 32'h12345678, 0);
    vec[5] = mk(3'b111, 5'd7, 5'd0, 5'd1, 32'h0, 0);
    vec[6] = mk(OP_LOAD, 5'd31, 5'd0, 5'd0, 32'hFFFFFFFF, 0);
    vec[7] = mk(3'b010, 5'd31, 5'd0, 5'd1, 32'h0, 4);

    cmd_valid = 0; cmd_op = 0; cmd_a1 = 0; cmd_a2 = 0; cmd_a3 = 0; cmd_data = 0;
    res_ready = 1;
    repeat (3) tick();
    rstp = 0;
    check_reset("reset");

    // Load r0 = 1.1: enable-only, enable+ld, gap.
    push_cmd(OP_LOAD, 5'd0, 5'd0, 5'd0, 32'h3F8CCCCD, 0, '0);
    tick();
    chk("ld_setup", {fpu_enable, fpu_ld, fpu_addr1, fpu_inp}, {1'b1, 1'b0, 5'd0, 32'h3F8CCCCD});
    tick();
    chk("ld_write", {fpu_enable, fpu_ld}, 2'b11);
    tick();
    chk("ld_gap", {fpu_enable, fpu_ld, busy}, 3'b001);
    tick();
    chk("ld_done", {busy, res_valid}, 2'b00);

    // r1 = -1.3, then op 010 with done after 6 EXEC cycles.
    push_cmd(OP_LOAD, 5'd1, 5'd0, 5'd0, 32'hBFA66666, 0, '0);
    wait_idle(20);
    res_ready = 0;
    done_delay = 6;
    push_cmd(3'b010, 5'd0, 5'd1, 5'd2, 32'h0, 1, exp_res(3'b010, 5'd0, 5'd1, 5'd2));
    n = 0; en_cnt = 0;
    while (!fpu_done && n < 40) begin
      tick();
      n++;
      if (fpu_enable) en_cnt++;
    end
    chk("exec_cycles_to_done", en_cnt, 6);
    tick();
    chk("arith_res_valid", {res_valid, fpu_enable}, 2'b10);
    chk("arith_res", {res_data, res_flags, res_status}, exp_res(3'b010, 5'd0, 5'd1, 5'd2));
    res_ready = 1;
    wait_idle(20);

    // Fill the FIFO behind a stalled EXEC; the 5th push must wait.
    done_delay = 0;
    push_cmd(3'b000, 5'd1, 5'd2, 5'd3, 32'h0, 1, exp_res(3'b000, 5'd1, 5'd2, 5'd3));
    for (int i = 0; i < 4; i++) begin
      push_cmd(OP_LOAD, 5'(4 + i), 5'd0, 5'd0, 32'hA0 + 32'(i), 0, '0);
      if (i == 2) chk("fifo_ready_at_3", cmd_ready, 1);
    end
    chk("fifo_ready_at_4", cmd_ready, 0);
    fork
      push_cmd(3'b001, 5'd8, 5'd9, 5'd10, 32'h0, 1, exp_res(3'b001, 5'd8, 5'd9, 5'd10));
      begin
        tick();
        chk("fifo_full_hold", {cmd_ready, fpu_enable}, 2'b01);
        done_delay = 2;
      end
    join
    wait_idle(200);

    // Second arithmetic command must wait for the first result to drain.
    res_ready = 0;
    done_delay = 3;
    push_cmd(3'b011, 5'd11, 5'd12, 5'd13, 32'h0, 1, exp_res(3'b011, 5'd11, 5'd12, 5'd13));
    push_cmd(3'b000, 5'd14, 5'd15, 5'd16, 32'h0, 1, exp_res(3'b000, 5'd14, 5'd15, 5'd16));
    n = 0;
    while (!res_valid && n < 50) begin
      tick();
      n++;
    end
    chk("hold_first_res", res_valid, 1);
    en_cnt = 0;
    repeat (6) begin
      tick();
      if (fpu_enable) en_cnt++;
    end
    chk("hold_no_issue", {en_cnt[7:0], busy}, {8'd0, 1'b1});
    res_ready = 1;
    wait_idle(50);

    // Illegal opcode: result in pop cycle + 1, no fpu activity.
    res_ready = 0;
    push_cmd(3'b110, 5'd1, 5'd1, 5'd1, 32'h0, 1, exp_res(3'b110, 5'd1, 5'd1, 5'd1));
    tick();
    chk("ill_res", {res_valid, res_data, res_flags, res_status}, {1'b1, 32'h0, 5'h0, ST_ILL});
    en_cnt = fpu_enable ? 1 : 0;
    repeat (2) begin
      tick();
      if (fpu_enable) en_cnt++;
    end
    chk("ill_no_enable", en_cnt, 0);
    res_ready = 1;
    wait_idle(20);

    // Vector table.
    for (int i = 0; i < 8; i++) begin
      done_delay = vec[i].dly;
      push_cmd(vec[i].op, vec[i].a1, vec[i].a2, vec[i].a3, vec[i].data, vec[i].has_res, vec[i].exp);
      wait_idle(60);
      tick();
      chk($sformatf("vec%0d_drained", i), sb_q.size(), 0);
    end

`ifdef FPU_SEQ_TIMEOUT_EN
    // Watchdog: done never comes.
    res_ready = 0;
    done_delay = 0;
    push_cmd(3'b001, 5'd20, 5'd21, 5'd22, 32'h0, 1, '{data: 32'h0, flags: 5'h0, status: ST_TMO});
    n = 0; en_cnt = 0;
    while (n < 40) begin
      tick();
      n++;
      if (res_valid) break;
      if (fpu_enable) en_cnt++;
    end
    chk("tmo_exec_cycles", en_cnt, TMO);
    chk("tmo_res", {res_valid, res_data, res_flags, res_status}, {1'b1, 32'h0, 5'h0, ST_TMO});
    res_ready = 1;
    wait_idle(20);
    push_cmd(3'b001, 5'd20, 5'd21, 5'd22, 32'h0, 0, '0);
`else
    done_delay = 0;
    push_cmd(3'b001, 5'd20, 5'd21, 5'd22, 32'h0, 0, '0);
    repeat (80) tick();
    chk("no_tmo_still_exec", {res_valid, fpu_enable}, 2'b01);
`endif

    // Reset mid-EXEC with a load still queued.
    push_cmd(OP_LOAD, 5'd9, 5'd9, 5'd9, 32'hDEADBEEF, 0, '0);
    chk("pre_reset_busy", {busy, fpu_enable}, 2'b11);
    rstp = 1;
    tick();
    check_reset("midop_reset");
    rstp = 0;
    sb_q.delete();
    iss_q.delete();
    last_inp = '0;
    done_delay = 2;
    tick();
    chk("post_reset_idle", {busy, fpu_enable, res_valid}, 3'b000);

    push_cmd(3'b000, 5'd5, 5'd6, 5'd7, 32'h0, 1, exp_res(3'b000, 5'd5, 5'd6, 5'd7));
    wait_idle(40);
    tick();
    chk("final_sb_empty", sb_q.size(), 0);
    chk("final_issue_empty", iss_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
